// File: rtl/sound_cmd_tx.sv
// sound_cmd_tx: drives 6-bit sound commands onto active-low pb plus hand for HOLD_CYCLES clocks, then forces GAP_CYCLES idle clocks.
// Latency: pb/hand change on the transfer edge; with the queue built in, 2 edges after the push when idle.
// Backpressure: cmd_ready is low outside IDLE; with the queue built in, it is low only while the 4-entry FIFO is full.
//
// Ports: clk_4e (E clock shared with the sound board), rst (synchronous, active-high),
//        cmd_valid/cmd_ready/cmd_data/cmd_hand (command handshake), pb (active-low, idle 6'h3F),
//        hand (handshake line), busy (FSM not idle or commands still queued).
// Build option: define SOUND_CMD_TX_QUEUE_EN to place a 4-entry command FIFO in front of the FSM.

`ifdef SOUND_CMD_TX_QUEUE_EN
// Small synchronous FIFO with registered read data (one clock read latency).
module sound_cmd_tx_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pop_dat <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                pop_dat <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end
endmodule
`endif

module sound_cmd_tx #(
    parameter int unsigned HOLD_CYCLES = 4096,
    parameter int unsigned GAP_CYCLES  = 256
) (
    input  logic       clk_4e,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_data,
    input  logic       cmd_hand,
    output logic [5:0] pb,
    output logic       hand,
    output logic       busy
);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);
    localparam logic [5:0]  PB_IDLE   = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [5:0]  pb_nxt;
    logic        hand_nxt;

    // Command presented to the FSM this cycle (only acted on in IDLE).
    logic        go;
    logic [5:0]  go_dat;
    logic        go_hand;

`ifdef SOUND_CMD_TX_QUEUE_EN
    logic       q_full;
    logic       q_empty;
    logic       q_pop;
    logic       pop_pend;
    logic [6:0] q_dat;

    assign cmd_ready = !rst && !q_full;

    // Pop once per idle period; the popped word arrives a clock later, while
    // the FSM is still in IDLE, so pop_pend blocks a second pop meanwhile.
    assign q_pop = (state == ST_IDLE) && !q_empty && !pop_pend;

    sound_cmd_tx_fifo #(
        .W     (7),
        .DEPTH (4)
    ) u_fifo (
        .clk      (clk_4e),
        .rst      (rst),
        .push     (cmd_valid && cmd_ready),
        .push_dat ({cmd_hand, cmd_data}),
        .pop      (q_pop),
        .pop_dat  (q_dat),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk_4e) begin
        if (rst) begin
            pop_pend <= 1'b0;
        end else begin
            pop_pend <= q_pop;
        end
    end

    assign go      = pop_pend;
    assign go_dat  = q_dat[5:0];
    assign go_hand = q_dat[6];
    assign busy    = (state != ST_IDLE) || !q_empty || pop_pend;
`else
    assign cmd_ready = !rst && (state == ST_IDLE);
    assign go        = cmd_valid && cmd_ready;
    assign go_dat    = cmd_data;
    assign go_hand   = cmd_hand;
    assign busy      = (state != ST_IDLE);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pb_nxt    = pb;
        hand_nxt  = hand;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    if (go_dat != 6'd0) begin
                        pb_nxt    = ~go_dat;
                        hand_nxt  = go_hand;
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = ST_HOLD;
                    end else begin
                        // Sound 0 means "nothing": consume it but keep the lines idle.
                        cnt_nxt   = GAP_LOAD;
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == 16'd0) begin
                    pb_nxt    = PB_IDLE;
                    hand_nxt  = 1'b0;
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 16'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk_4e) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
            pb    <= PB_IDLE;
            hand  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pb    <= pb_nxt;
            hand  <= hand_nxt;
        end
    end
endmodule

// File: tb/tb_sound_cmd_tx.sv
// Testbench for sound_cmd_tx with HOLD_CYCLES=4, GAP_CYCLES=2.
// Expected pb/hand words are queued when a command is driven and compared when pb leaves idle.
module tb_sound_cmd_tx;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    // Transfer edge, HOLD clocks in HOLD, GAP clocks in GAP, then one IDLE clock to accept.
    localparam int SPACING = HOLD + GAP + 1;

    logic       clk_4e = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [5:0] cmd_data = 6'd0;
    logic       cmd_hand = 1'b0;
    logic [5:0] pb;
    logic       hand;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [6:0] exp_q[$];
    int         onset_q[$];
    logic [6:0] exp_v;
    bit         in_run = 1'b0;
    int         run_len = 0;
    bit         run_rst = 1'b0;

    sound_cmd_tx #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_4e    (clk_4e),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_hand  (cmd_hand),
        .pb        (pb),
        .hand      (hand),
        .busy      (busy)
    );

    initial forever #5 clk_4e = ~clk_4e;

    always @(posedge clk_4e) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every pb activation is popped against the queue and
    // every undisturbed activation must last exactly HOLD clocks.
    always @(negedge clk_4e) begin
        if (!$isunknown(pb)) begin
            if (pb != 6'h3F) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 1;
                    run_rst = rst;
                    onset_q.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got hand/pb=%b/%h, nothing expected", hand, pb);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if ({hand, pb} !== exp_v) begin
                            errors++;
                            $display("FAIL sb_value: got hand/pb=%b/%h want %b/%h", hand, pb, exp_v[6], exp_v[5:0]);
                        end
                    end
                end else begin
                    run_len++;
                    run_rst = run_rst | rst;
                end
            end else if (in_run) begin
                in_run = 1'b0;
                if (!run_rst && !rst) begin
                    checks++;
                    if (run_len != HOLD) begin
                        errors++;
                        $display("FAIL sb_hold_len: got %0d clocks want %0d", run_len, HOLD);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_4e);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (5) step();
        checks++; if (pb !== 6'h3F) begin errors++; $display("FAIL reset_pb: got %h want 3f", pb); end
        checks++; if (hand !== 1'b0) begin errors++; $display("FAIL reset_hand: got %b want 0", hand); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

`ifndef SOUND_CMD_TX_QUEUE_EN
    task automatic test_single();
        cmd_valid = 1'b1;
        cmd_data  = 6'h05;
        cmd_hand  = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre: got %b want 1", cmd_ready); end
        exp_q.push_back({1'b1, 6'h3A});
        step();
        // Inputs change while not ready; they must be ignored.
        cmd_valid = 1'b0;
        cmd_data  = 6'h2A;
        cmd_hand  = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            checks++;
            if ({hand, pb} !== {1'b1, 6'h3A}) begin errors++; $display("FAIL single_hold[%0d]: got %b/%h want 1/3a", i, hand, pb); end
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL single_hold_ready[%0d]: got %b want 0", i, cmd_ready); end
            step();
        end
        for (int i = 0; i < GAP; i++) begin
            checks++;
            if ({hand, pb} !== {1'b0, 6'h3F}) begin errors++; $display("FAIL single_gap[%0d]: got %b/%h want 0/3f", i, hand, pb); end
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_gap_ctl[%0d]: got ready=%b busy=%b want 0/1", i, cmd_ready, busy); end
            step();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready_post: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_post: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int got;
        int last_e;
        int first_d;
        logic [5:0] samp [24];
        t0 = -1; t1 = -1; got = 0; last_e = -1; first_d = -1;
        cmd_valid = 1'b1;
        cmd_data  = 6'h01;
        cmd_hand  = 1'b0;
        exp_q.push_back({1'b0, 6'h3E});
        for (int c = 0; c < 24; c++) begin
            if (cmd_valid && cmd_ready) begin
                if (got == 0) t0 = c; else t1 = c;
                got++;
            end
            step();
            samp[c] = pb;
            if (got == 1 && cmd_data == 6'h01) begin
                cmd_data = 6'h02;
                exp_q.push_back({1'b0, 6'h3D});
            end else if (got == 2) begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (got != 2) begin errors++; $display("FAIL b2b_count: got %0d transfers want 2", got); end
        checks++; if (t1 - t0 != SPACING) begin errors++; $display("FAIL b2b_spacing: got %0d clocks want %0d", t1 - t0, SPACING); end
        for (int c = 0; c < 24; c++) begin
            if (samp[c] === 6'h3E) last_e = c;
            if (samp[c] === 6'h3D && first_d < 0) first_d = c;
        end
        checks++;
        if (first_d - last_e - 1 != GAP + 1) begin
            errors++; $display("FAIL b2b_idle: got %0d idle clocks want %0d", first_d - last_e - 1, GAP + 1);
        end
    endtask

    task automatic test_zero();
        cmd_valid = 1'b1;
        cmd_data  = 6'h00;
        cmd_hand  = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_pre: got %b want 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_low[%0d]: got %b want 0", i, cmd_ready); end
            checks++;
            if ({hand, pb} !== {1'b0, 6'h3F}) begin errors++; $display("FAIL zero_lines[%0d]: got %b/%h want 0/3f", i, hand, pb); end
            step();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_post: got %b want 1", cmd_ready); end
        checks++; if (pb !== 6'h3F) begin errors++; $display("FAIL zero_pb_post: got %h want 3f", pb); end
    endtask

    task automatic test_reset_mid_hold();
        cmd_valid = 1'b1;
        cmd_data  = 6'h10;
        cmd_hand  = 1'b1;
        exp_q.push_back({1'b1, 6'h2F});
        step();
        cmd_valid = 1'b0;
        checks++; if (pb !== 6'h2F) begin errors++; $display("FAIL rmh_active: got %h want 2f", pb); end
        step();
        rst = 1'b1;
        step();
        checks++; if ({hand, pb} !== {1'b0, 6'h3F}) begin errors++; $display("FAIL rmh_lines: got %b/%h want 0/3f", hand, pb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmh_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rmh_ready_rst: got %b want 0", cmd_ready); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmh_ready_rel: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1;
        cmd_data  = 6'h3F;
        cmd_hand  = 1'b0;
        exp_q.push_back({1'b0, 6'h00});
        step();
        cmd_valid = 1'b0;
        checks++; if (pb !== 6'h00) begin errors++; $display("FAIL rmh_next: got %h want 00", pb); end
        repeat (HOLD + GAP) step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmh_ready_end: got %b want 1", cmd_ready); end
    endtask
`else
    task automatic test_queue();
        int a_acc;
        int sent;
        int acc [5];
        sent = 0;
        onset_q.delete();
        cmd_valid = 1'b1;
        cmd_data  = 6'h21;
        cmd_hand  = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL q_ready_pre: got %b want 1", cmd_ready); end
        a_acc = cyc + 1;
        exp_q.push_back({1'b0, ~6'h21});
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && onset_q.size() == 0; c++) step();
        checks++;
        if (onset_q.size() != 1 || onset_q[0] != a_acc + 2) begin
            errors++; $display("FAIL q_latency: got %0d onsets first=%0d want 1 at %0d", onset_q.size(), (onset_q.size() > 0) ? onset_q[0] : -1, a_acc + 2);
        end
        // Five commands offered with cmd_valid held while the first one is still on pb.
        cmd_valid = 1'b1;
        cmd_data  = 6'h11;
        cmd_hand  = 1'b1;
        for (int c = 0; c < 100 && sent < 5; c++) begin
            if (cmd_ready) begin
                acc[sent] = cyc + 1;
                exp_q.push_back({cmd_hand, ~cmd_data});
                sent++;
                step();
                if (sent < 5) begin
                    cmd_data = 6'h11 + 6'(sent);
                    cmd_hand = ~cmd_hand;
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                step();
            end
        end
        cmd_valid = 1'b0;
        checks++; if (sent != 5) begin errors++; $display("FAIL q_accept_count: got %0d want 5", sent); end
        if (sent == 5) begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (acc[k] != acc[0] + k) begin errors++; $display("FAIL q_b2b[%0d]: got edge %0d want %0d", k, acc[k], acc[0] + k); end
            end
            checks++;
            if (acc[4] <= acc[3] + 1) begin errors++; $display("FAIL q_stall: 5th accepted at %0d, 4th at %0d, want a stall", acc[4], acc[3]); end
        end
        for (int c = 0; c < 200 && (busy || exp_q.size() != 0 || in_run); c++) step();
        checks++; if (busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL q_drain: busy=%b pending=%0d want 0/0", busy, exp_q.size()); end
        checks++; if (onset_q.size() != 6) begin errors++; $display("FAIL q_onsets: got %0d want 6", onset_q.size()); end
        for (int k = 1; k < onset_q.size(); k++) begin
            checks++;
            if (onset_q[k] - onset_q[k-1] != SPACING + 1) begin
                errors++; $display("FAIL q_spacing[%0d]: got %0d clocks want %0d", k, onset_q[k] - onset_q[k-1], SPACING + 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SOUND_CMD_TX_QUEUE_EN
        test_queue();
`else
        test_single();
        test_back_to_back();
        test_zero();
        test_reset_mid_hold();
`endif
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d expected commands never appeared on pb", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
